ctrl_pipeline: RTL and testbench

- Parametrised successor to the single-issue pipelined controller.
- Carries a generic decoded control bundle plus register addresses from Decode through Execute, Memory and Writeback.
- Adds what the fixed controller lacks:
  - load-use hazard detection and bubble insertion;
  - EX-stage forwarding selects;
  - multi-cycle Execute handshake (mul/div) with pipeline hold;
  - gated branch redirect;
  - saturating stall-cycle counter.
- Sits between the main/ALU decoders and the datapath/hazard muxes.

---
 rtl/ctrl_pkg.sv | 30 +++
 rtl/ctrl_stage_reg.sv | 42 ++++
 rtl/ctrl_pipeline.sv | 122 ++++++++++++
 tb/tb_ctrl_pipeline.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared types and constants for the pipelined controller: multi-cycle FSM
// states, operand-forwarding select codes and the pipeline-bubble constant.
package ctrl_pkg;

  typedef enum logic {
    MC_IDLE = 1'b0,
    MC_BUSY = 1'b1
  } mc_state_t;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  // A bubble is an invalid slot; its ctrl and rd fields are cleared alongside.
  localparam logic BUBBLE_VLD = 1'b0;

  // M has priority over W; x0 hits are already excluded by the caller.
  function automatic logic [1:0] fwdSel(input logic mHit, input logic wHit);
    logic [1:0] sel;
    if (mHit) begin
      sel = FWD_M;
    end else if (wHit) begin
      sel = FWD_W;
    end else begin
      sel = FWD_RF;
    end
    return sel;
  endfunction

endpackage

// File: rtl/ctrl_stage_reg.sv
// One pipeline stage register (valid, control bundle, destination register).
// hold keeps the current contents and takes priority over bubble.
module ctrl_stage_reg
  import ctrl_pkg::*;
#(
  parameter int CW = 24,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          hold,
  input  logic          bubble,
  input  logic          vldIn,
  input  logic [CW-1:0] ctrlIn,
  input  logic [RW-1:0] rdIn,
  output logic          vldOut,
  output logic [CW-1:0] ctrlOut,
  output logic [RW-1:0] rdOut
);

  // Stage update: reset, hold, bubble, then load.
  always_ff @(posedge clk) begin
    if (!reset) begin
      vldOut  <= 1'b0;
      ctrlOut <= '0;
      rdOut   <= '0;
    end else if (hold) begin
      vldOut  <= vldOut;
      ctrlOut <= ctrlOut;
      rdOut   <= rdOut;
    end else if (bubble) begin
      vldOut  <= BUBBLE_VLD;
      ctrlOut <= '0;
      rdOut   <= '0;
    end else begin
      vldOut  <= vldIn;
      ctrlOut <= ctrlIn;
      rdOut   <= rdIn;
    end
  end

endmodule

// File: rtl/ctrl_pipeline.sv
// Decode-to-Writeback control pipeline with load-use bubbling, EX forwarding
// selects, multi-cycle Execute hold, gated redirect and a stall-cycle counter.
module ctrl_pipeline
  import ctrl_pkg::*;
#(
  parameter int CW           = 24,
  parameter int RW           = 5,
  parameter int REGWRITE_BIT = 0,
  parameter int MEMTOREG_BIT = 1,
  parameter int MC_BIT       = 2,
  parameter int CNTW         = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_d,
  input  logic [CW-1:0]   ctrl_d,
  input  logic [RW-1:0]   rs1_d,
  input  logic [RW-1:0]   rs2_d,
  input  logic [RW-1:0]   rd_d,
  input  logic            use_rs1_d,
  input  logic            use_rs2_d,
  input  logic            redirect_d,
  input  logic            mc_done,
  output logic [CW-1:0]   ctrl_e,
  output logic [CW-1:0]   ctrl_m,
  output logic [CW-1:0]   ctrl_w,
  output logic            vld_e,
  output logic            vld_m,
  output logic            vld_w,
  output logic [RW-1:0]   rd_e,
  output logic [RW-1:0]   rd_m,
  output logic [RW-1:0]   rd_w,
  output logic [1:0]      fwd_a_e,
  output logic [1:0]      fwd_b_e,
  output logic            stall_fd,
  output logic            flush_fd,
  output logic            mc_start,
  output logic            mc_busy,
  output logic [CNTW-1:0] stall_cnt
);

  mc_state_t     mcState_r;
  logic [RW-1:0] rs1E_r, rs2E_r;
  logic          lu_s, mcHold_s;
  logic [CW-1:0] ctrlDIn_s;
  logic          mHitA_s, wHitA_s, mHitB_s, wHitB_s;

  // Hazard, handshake and forwarding terms.
  always_comb begin
    lu_s = valid_d & vld_e & ctrl_e[MEMTOREG_BIT] & (rd_e != '0) &
           ((use_rs1_d & (rs1_d == rd_e)) | (use_rs2_d & (rs2_d == rd_e)));
    mc_start  = (mcState_r == MC_IDLE) & vld_e & ctrl_e[MC_BIT];
    mc_busy   = (mcState_r == MC_BUSY);
    mcHold_s  = mc_start | (mc_busy & ~mc_done);
    stall_fd  = lu_s | mcHold_s;
    flush_fd  = redirect_d & ~stall_fd;
    if (valid_d) begin
      ctrlDIn_s = ctrl_d;
    end else begin
      ctrlDIn_s = '0;
    end
    mHitA_s = vld_m & ctrl_m[REGWRITE_BIT] & (rd_m != '0) & (rd_m == rs1E_r);
    wHitA_s = vld_w & ctrl_w[REGWRITE_BIT] & (rd_w != '0) & (rd_w == rs1E_r);
    mHitB_s = vld_m & ctrl_m[REGWRITE_BIT] & (rd_m != '0) & (rd_m == rs2E_r);
    wHitB_s = vld_w & ctrl_w[REGWRITE_BIT] & (rd_w != '0) & (rd_w == rs2E_r);
    fwd_a_e = fwdSel(mHitA_s, wHitA_s);
    fwd_b_e = fwdSel(mHitB_s, wHitB_s);
  end

  ctrl_stage_reg #(.CW(CW), .RW(RW)) uStageE (
    .clk(clk), .reset(reset), .hold(mcHold_s), .bubble(lu_s),
    .vldIn(valid_d), .ctrlIn(ctrlDIn_s), .rdIn(rd_d),
    .vldOut(vld_e), .ctrlOut(ctrl_e), .rdOut(rd_e)
  );

  ctrl_stage_reg #(.CW(CW), .RW(RW)) uStageM (
    .clk(clk), .reset(reset), .hold(1'b0), .bubble(mcHold_s),
    .vldIn(vld_e), .ctrlIn(ctrl_e), .rdIn(rd_e),
    .vldOut(vld_m), .ctrlOut(ctrl_m), .rdOut(rd_m)
  );

  ctrl_stage_reg #(.CW(CW), .RW(RW)) uStageW (
    .clk(clk), .reset(reset), .hold(1'b0), .bubble(1'b0),
    .vldIn(vld_m), .ctrlIn(ctrl_m), .rdIn(rd_m),
    .vldOut(vld_w), .ctrlOut(ctrl_w), .rdOut(rd_w)
  );

  // Execute-stage source registers travel with the E stage.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rs1E_r <= '0;
      rs2E_r <= '0;
    end else if (mcHold_s) begin
      rs1E_r <= rs1E_r;
      rs2E_r <= rs2E_r;
    end else if (lu_s) begin
      rs1E_r <= '0;
      rs2E_r <= '0;
    end else begin
      rs1E_r <= rs1_d;
      rs2E_r <= rs2_d;
    end
  end

  // Multi-cycle handshake FSM and saturating stall counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mcState_r <= MC_IDLE;
      stall_cnt <= '0;
    end else begin
      case (mcState_r)
        MC_IDLE: if (mc_start) mcState_r <= MC_BUSY;
        MC_BUSY: if (mc_done)  mcState_r <= MC_IDLE;
        default: mcState_r <= MC_IDLE;
      endcase
      if (stall_fd && (stall_cnt != {CNTW{1'b1}})) begin
        stall_cnt <= stall_cnt + {{(CNTW-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Directed self-checking bench for ctrl_pipeline (counter narrowed to 4 bits
// so saturation is reachable quickly).
module tb_ctrl_pipeline;
  localparam int CW = 24, RW = 5, CNTW = 4;

  logic clk = 1'b0;
  logic reset, valid_d, use_rs1_d, use_rs2_d, redirect_d, mc_done;
  logic [CW-1:0] ctrl_d, ctrl_e, ctrl_m, ctrl_w;
  logic [RW-1:0] rs1_d, rs2_d, rd_d, rd_e, rd_m, rd_w;
  logic vld_e, vld_m, vld_w, stall_fd, flush_fd, mc_start, mc_busy;
  logic [1:0] fwd_a_e, fwd_b_e;
  logic [CNTW-1:0] stall_cnt;

  int nTests = 0;
  int nFail  = 0;

  always #5 clk = ~clk;

  ctrl_pipeline #(.CW(CW), .RW(RW), .CNTW(CNTW)) dut (
    .clk(clk), .reset(reset), .valid_d(valid_d), .ctrl_d(ctrl_d),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
    .use_rs1_d(use_rs1_d), .use_rs2_d(use_rs2_d),
    .redirect_d(redirect_d), .mc_done(mc_done),
    .ctrl_e(ctrl_e), .ctrl_m(ctrl_m), .ctrl_w(ctrl_w),
    .vld_e(vld_e), .vld_m(vld_m), .vld_w(vld_w),
    .rd_e(rd_e), .rd_m(rd_m), .rd_w(rd_w),
    .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e),
    .stall_fd(stall_fd), .flush_fd(flush_fd),
    .mc_start(mc_start), .mc_busy(mc_busy), .stall_cnt(stall_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nTests++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [CW-1:0] c, input logic [RW-1:0] r1,
                       input logic [RW-1:0] r2, input logic [RW-1:0] rd,
                       input logic u1, input logic u2);
    valid_d = v; ctrl_d = c; rs1_d = r1; rs2_d = r2; rd_d = rd;
    use_rs1_d = u1; use_rs2_d = u2;
  endtask

  task automatic idle();
    drive(1'b0, 24'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    redirect_d = 1'b0;
    mc_done = 1'b0;
  endtask

  initial begin
    idle();
    // Reset with a live, all-ones instruction at Decode
    reset = 1'b0;
    drive(1'b1, 24'hFFFFFF, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1);
    tick(); tick();
    chk("rst_vld_e", {31'd0, vld_e}, 32'd0);
    chk("rst_vld_m", {31'd0, vld_m}, 32'd0);
    chk("rst_vld_w", {31'd0, vld_w}, 32'd0);
    chk("rst_ctrl_e", {8'd0, ctrl_e}, 32'd0);
    chk("rst_ctrl_m", {8'd0, ctrl_m}, 32'd0);
    chk("rst_ctrl_w", {8'd0, ctrl_w}, 32'd0);
    chk("rst_cnt", {28'd0, stall_cnt}, 32'd0);
    chk("rst_busy", {31'd0, mc_busy}, 32'd0);
    reset = 1'b1;
    idle();
    tick(); tick(); tick();

    // Load-use: load x5, then add reading x5
    drive(1'b1, 24'h000003, 5'd0, 5'd0, 5'd5, 1'b0, 1'b0);
    #1 chk("lu_pre_stall", {31'd0, stall_fd}, 32'd0);
    tick();
    drive(1'b1, 24'h000001, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0);
    #1 chk("lu_stall", {31'd0, stall_fd}, 32'd1);
    tick();
    chk("lu_bubble_vld_e", {31'd0, vld_e}, 32'd0);
    chk("lu_stall_clear", {31'd0, stall_fd}, 32'd0);
    chk("lu_load_in_m", {27'd0, rd_m}, 32'd5);
    chk("lu_cnt", {28'd0, stall_cnt}, 32'd1);
    tick();
    chk("lu_add_vld_e", {31'd0, vld_e}, 32'd1);
    chk("lu_add_rd_e", {27'd0, rd_e}, 32'd6);
    chk("lu_fwd_a", {30'd0, fwd_a_e}, 32'd1);
    chk("lu_fwd_b", {30'd0, fwd_b_e}, 32'd0);
    idle(); tick(); tick(); tick();

    // Forwarding priority: two writers of x7, M must win
    drive(1'b1, 24'h000001, 5'd0, 5'd0, 5'd7, 1'b0, 1'b0); tick();
    drive(1'b1, 24'h000001, 5'd0, 5'd0, 5'd7, 1'b0, 1'b0); tick();
    drive(1'b1, 24'h000001, 5'd7, 5'd7, 5'd8, 1'b1, 1'b1); tick();
    chk("fwd_a_m", {30'd0, fwd_a_e}, 32'd2);
    chk("fwd_b_m", {30'd0, fwd_b_e}, 32'd2);
    idle(); tick(); tick(); tick();
    // Same pattern on x0: never forwarded
    drive(1'b1, 24'h000001, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0); tick();
    drive(1'b1, 24'h000001, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0); tick();
    drive(1'b1, 24'h000001, 5'd0, 5'd0, 5'd8, 1'b1, 1'b1); tick();
    chk("fwd_a_x0", {30'd0, fwd_a_e}, 32'd0);
    chk("fwd_b_x0", {30'd0, fwd_b_e}, 32'd0);
    idle(); tick(); tick(); tick();

    // Multi-cycle op: done arrives 4 cycles after busy rises
    drive(1'b1, 24'h000005, 5'd0, 5'd0, 5'd9, 1'b0, 1'b0); tick();
    idle();
    #1 chk("mc_start", {31'd0, mc_start}, 32'd1);
    chk("mc_stall_idle", {31'd0, stall_fd}, 32'd1);
    tick();
    chk("mc_start_pulse", {31'd0, mc_start}, 32'd0);
    chk("mc_busy", {31'd0, mc_busy}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      chk("mc_hold_vld_e", {31'd0, vld_e}, 32'd1);
      chk("mc_hold_vld_m", {31'd0, vld_m}, 32'd0);
      tick();
    end
    chk("mc_hold_rd_e", {27'd0, rd_e}, 32'd9);
    tick();
    mc_done = 1'b1;
    #1 chk("mc_done_stall", {31'd0, stall_fd}, 32'd0);
    tick();
    mc_done = 1'b0;
    chk("mc_op_in_m", {31'd0, vld_m}, 32'd1);
    chk("mc_op_rd_m", {27'd0, rd_m}, 32'd9);
    chk("mc_idle_again", {31'd0, mc_busy}, 32'd0);
    chk("mc_cnt", {28'd0, stall_cnt}, 32'd6);
    idle(); tick(); tick(); tick();

    // Redirect while load-use stalled is deferred, branch then enters E
    drive(1'b1, 24'h000003, 5'd0, 5'd0, 5'd3, 1'b0, 1'b0); tick();
    drive(1'b1, 24'h000100, 5'd3, 5'd0, 5'd0, 1'b1, 1'b0);
    redirect_d = 1'b1;
    #1 chk("redir_stalled", {31'd0, stall_fd}, 32'd1);
    chk("redir_no_flush", {31'd0, flush_fd}, 32'd0);
    tick();
    chk("redir_flush", {31'd0, flush_fd}, 32'd1);
    tick();
    redirect_d = 1'b0;
    chk("redir_br_vld_e", {31'd0, vld_e}, 32'd1);
    chk("redir_br_ctrl_e", {8'd0, ctrl_e}, 32'h000100);
    chk("redir_cnt", {28'd0, stall_cnt}, 32'd7);
    idle(); tick(); tick(); tick();

    // Counter saturation under a long multi-cycle hold
    drive(1'b1, 24'h000004, 5'd0, 5'd0, 5'd4, 1'b0, 1'b0); tick();
    idle();
    for (int i = 0; i < 12; i++) tick();
    chk("cnt_sat", {28'd0, stall_cnt}, 32'd15);
    mc_done = 1'b1; tick();
    mc_done = 1'b0;
    chk("cnt_sat_hold", {28'd0, stall_cnt}, 32'd15);
    idle(); tick(); tick(); tick();

    // Reset while BUSY, then a stray done pulse
    drive(1'b1, 24'h000004, 5'd0, 5'd0, 5'd4, 1'b0, 1'b0); tick();
    idle(); tick();
    chk("rb_busy", {31'd0, mc_busy}, 32'd1);
    reset = 1'b0; tick();
    reset = 1'b1;
    chk("rb_busy_clr", {31'd0, mc_busy}, 32'd0);
    chk("rb_vld_e", {31'd0, vld_e}, 32'd0);
    chk("rb_cnt", {28'd0, stall_cnt}, 32'd0);
    mc_done = 1'b1;
    #1 chk("rb_no_start", {31'd0, mc_start}, 32'd0);
    chk("rb_no_stall", {31'd0, stall_fd}, 32'd0);
    tick();
    mc_done = 1'b0;
    chk("rb_vld_m", {31'd0, vld_m}, 32'd0);
    chk("rb_still_idle", {31'd0, mc_busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule
